// File: rtl/approx_fp32_pkg.sv
// Shared field widths, constants and pipeline types for the approximate
// binary32 multiplier.
package approx_fp32_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MASK_W = 22;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // Everything the round/pack stage needs, carried between stage 1 and 2.
    typedef struct packed {
        logic        sign;
        logic [9:0]  exp;
        logic [47:0] prod;
        logic        is_nan;
        logic        is_inf;
        logic        is_zero;
    } mul_stage_t;

endpackage

// File: rtl/fp32_round_pack.sv
// Normalizes and rounds (RNE) the 48-bit significand product and packs the
// binary32 result; adds IEEE status flags when FPMUL_FLAGS_EN is defined.
module fp32_round_pack
    import approx_fp32_pkg::*;
(
    input  logic               sign,
    input  logic signed [9:0]  exp_in,
    input  logic [47:0]        prod,
    input  logic               is_nan,
    input  logic               is_inf,
    input  logic               is_zero,
    output logic [31:0]        result
`ifdef FPMUL_FLAGS_EN
    ,
    output logic [3:0]         flags
`endif
);

    logic              norm;
    logic              guard;
    logic              rnd;
    logic              sticky;
    logic              round_up;
    logic              carry;
    logic              ovf;
    logic              unf;
    logic [22:0]       frac_raw;
    logic [23:0]       mant;
    logic signed [9:0] exp_fin;

    always_comb begin
        norm     = prod[47];
        frac_raw = norm ? prod[46:24] : prod[45:23];
        guard    = norm ? prod[23] : prod[22];
        rnd      = norm ? prod[22] : prod[21];
        sticky   = norm ? (|prod[21:0]) : (|prod[20:0]);
        round_up = guard & (rnd | sticky | frac_raw[0]);
        // A carry out of the 23-bit fraction leaves it all zeros, i.e. 1.0 x 2^(e+1).
        mant     = {1'b0, frac_raw} + {23'd0, round_up};
        carry    = mant[23];
        exp_fin  = exp_in + $signed({9'd0, norm}) + $signed({9'd0, carry});
        ovf      = (exp_fin >= 10'sd255);
        unf      = (exp_fin <= 10'sd0);

        if (is_nan)
            result = QNAN;
        else if (is_inf)
            result = {sign, POS_INF[30:0]};
        else if (is_zero)
            result = {sign, 31'd0};
        else if (ovf)
            result = {sign, POS_INF[30:0]};
        else if (unf)
            result = {sign, 31'd0};
        else
            result = {sign, exp_fin[7:0], mant[22:0]};
    end

`ifdef FPMUL_FLAGS_EN
    logic special;

    always_comb begin
        special  = is_nan | is_inf | is_zero;
        flags[3] = is_nan;
        flags[2] = ~special & ovf;
        flags[1] = ~special & ~ovf & unf;
        flags[0] = ~special & (guard | rnd | sticky | ovf | unf);
    end
`endif

endmodule

// File: rtl/approx_fp32_mul.sv
// Pipelined binary32 multiplier with a run-time fraction keep-mask.
// Optional status flags output enabled by defining FPMUL_FLAGS_EN.
module approx_fp32_mul
    import approx_fp32_pkg::*;
#(
    parameter int PIPE_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       a,
    input  logic [31:0]       b,
    input  logic [MASK_W-1:0] conf_bit_mask,
    output logic              out_valid,
    output logic [31:0]       result
`ifdef FPMUL_FLAGS_EN
    ,
    output logic [3:0]        flags
`endif
);

    fp32_t       fa;
    fp32_t       fb;
    logic        a_nan, a_inf, a_zero;
    logic        b_nan, b_inf, b_zero;
    logic [23:0] sig_a;
    logic [23:0] sig_b;
    mul_stage_t  s1_d;
    mul_stage_t  s1;
    logic        s1_valid;
    logic [31:0] rp_result;

    assign fa = a;
    assign fb = b;

    // Special detection uses the unmasked fraction so masking can never turn a NaN into Inf.
    always_comb begin
        a_nan  = (fa.exp == 8'hFF) && (fa.frac != '0);
        a_inf  = (fa.exp == 8'hFF) && (fa.frac == '0);
        a_zero = (fa.exp == 8'h00);
        b_nan  = (fb.exp == 8'hFF) && (fb.frac != '0);
        b_inf  = (fb.exp == 8'hFF) && (fb.frac == '0);
        b_zero = (fb.exp == 8'h00);

        sig_a = {1'b1, fa.frac[22], fa.frac[21:0] & conf_bit_mask};
        sig_b = {1'b1, fb.frac[22], fb.frac[21:0] & conf_bit_mask};

        s1_d.sign    = fa.sign ^ fb.sign;
        s1_d.exp     = $signed({2'b00, fa.exp}) + $signed({2'b00, fb.exp}) - 10'(BIAS);
        s1_d.prod    = sig_a * sig_b;
        s1_d.is_nan  = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
        s1_d.is_inf  = a_inf | b_inf;
        s1_d.is_zero = a_zero | b_zero;
    end

    // Any value other than 2 builds the single-stage variant.
    generate
        if (PIPE_STAGES == 2) begin : g_pipe2
            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_valid <= 1'b0;
                    s1       <= '0;
                end else begin
                    s1_valid <= in_valid;
                    if (in_valid)
                        s1 <= s1_d;
                end
            end
        end else begin : g_pipe1
            assign s1_valid = in_valid;
            assign s1       = s1_d;
        end
    endgenerate

`ifdef FPMUL_FLAGS_EN
    logic [3:0] rp_flags;
`endif

    fp32_round_pack u_round_pack (
        .sign    (s1.sign),
        .exp_in  (s1.exp),
        .prod    (s1.prod),
        .is_nan  (s1.is_nan),
        .is_inf  (s1.is_inf),
        .is_zero (s1.is_zero),
        .result  (rp_result)
`ifdef FPMUL_FLAGS_EN
        ,
        .flags   (rp_flags)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid)
                result <= rp_result;
        end
    end

`ifdef FPMUL_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst)
            flags <= '0;
        else if (s1_valid)
            flags <= rp_flags;
    end
`endif

endmodule

// File: tb/tb_approx_fp32_mul.sv
// Scoreboard bench for approx_fp32_mul: directed vectors, a random stream
// against an integer reference model, and reset in the middle of a burst.
module tb_approx_fp32_mul;

    localparam int PIPE_STAGES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [21:0] conf_bit_mask;
    logic        out_valid;
    logic [31:0] result;
`ifdef FPMUL_FLAGS_EN
    logic [3:0]  flags;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    approx_fp32_mul #(.PIPE_STAGES(PIPE_STAGES)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .a             (a),
        .b             (b),
        .conf_bit_mask (conf_bit_mask),
        .out_valid     (out_valid),
        .result        (result)
`ifdef FPMUL_FLAGS_EN
        ,
        .flags         (flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, actual, expected);
        end
    endtask

    // Independent model: round-to-nearest-even by add-and-truncate on the full product.
    function automatic logic [31:0] refMul(input logic [31:0] x, input logic [31:0] y, input logic [21:0] m);
        logic            s;
        int              ex, ey, e, sh;
        logic [22:0]     fx, fy;
        bit              xn, yn, xi, yi, xz, yz;
        longint unsigned sx, sy, p, q, half, lsb;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        fx = x[22:0];
        fy = y[22:0];
        xn = (ex == 255) && (fx != 0);
        yn = (ey == 255) && (fy != 0);
        xi = (ex == 255) && (fx == 0);
        yi = (ey == 255) && (fy == 0);
        xz = (ex == 0);
        yz = (ey == 0);
        if (xn || yn || (xi && yz) || (xz && yi)) return 32'h7FC0_0000;
        if (xi || yi) return {s, 8'hFF, 23'd0};
        if (xz || yz) return {s, 31'd0};
        sx = {40'd0, 1'b1, fx[22], fx[21:0] & m};
        sy = {40'd0, 1'b1, fy[22], fy[21:0] & m};
        p  = sx * sy;
        e  = ex + ey - 127;
        sh = p[47] ? 24 : 23;
        if (p[47]) e++;
        half = 64'd1 << (sh - 1);
        lsb  = (p >> sh) & 64'd1;
        q    = (p + half - 64'd1 + lsb) >> sh;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e++;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], q[22:0]};
    endfunction

    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic [21:0] m,
                                 input logic [31:0] expected);
        @(posedge clk);
        #1;
        in_valid      = 1'b1;
        a             = x;
        b             = y;
        conf_bit_mask = m;
        exp_q.push_back(expected);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    function automatic logic [31:0] randOperand();
        logic [7:0] e;
        int         r;
        r = $urandom_range(0, 19);
        if (r == 0)      e = 8'h00;
        else if (r == 1) e = 8'hFF;
        else             e = 8'($urandom_range(60, 195));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // Monitor: every out_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_out_valid: got result %08h expected no output", result);
            end else begin
                checkOutput("result", result, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got no finish expected finish");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        logic [31:0] x, y;
        rst           = 1'b1;
        in_valid      = 1'b0;
        a             = '0;
        b             = '0;
        conf_bit_mask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        $display("[TB] identity and latency");
        applyStimulus(32'h3F80_0000, 32'h3F80_0000, 22'h3FFFFF, 32'h3F80_0000);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("valid_cycle1", {31'd0, out_valid}, {31'd0, PIPE_STAGES == 1});
        @(negedge clk);
        checkOutput("valid_cycle2", {31'd0, out_valid}, {31'd0, PIPE_STAGES == 2});
        @(negedge clk);
        checkOutput("valid_cycle3", {31'd0, out_valid}, 32'd0);
        checkOutput("result_hold", result, 32'h3F80_0000);

        $display("[TB] directed burst");
        applyStimulus(32'hBFC0_0000, 32'h4000_0000, 22'h3FFFFF, 32'hC040_0000);
        applyStimulus(32'h3F80_0001, 32'h3F80_0000, 22'h3FFFFF, 32'h3F80_0001);
        applyStimulus(32'h3F80_0001, 32'h3F80_0000, 22'h3FFFFE, 32'h3F80_0000);
        applyStimulus(32'h3F80_0001, 32'h3F80_0000, 22'h00003F, 32'h3F80_0001);
        applyStimulus(32'h3FFF_FFFF, 32'h3F80_0000, 22'h000000, 32'h3FC0_0000);
        applyStimulus(32'h7F80_0000, 32'h0000_0000, 22'h3FFFFF, 32'h7FC0_0000);
        applyStimulus(32'h7F00_0000, 32'h7F00_0000, 22'h3FFFFF, 32'h7F80_0000);
        applyStimulus(32'h0000_0001, 32'h3F80_0000, 22'h3FFFFF, 32'h0000_0000);
        applyStimulus(32'h7FC0_0001, 32'h3F80_0000, 22'h000000, 32'h7FC0_0000);
        applyStimulus(32'hC000_0000, 32'h7F80_0000, 22'h3FFFFF, 32'hFF80_0000);
        applyStimulus(32'h8000_0000, 32'h40A0_0000, 22'h3FFFFF, 32'h8000_0000);
        applyStimulus(32'h0080_0000, 32'h0080_0000, 22'h3FFFFF, 32'h0000_0000);
        idle(1);
        drain();

        $display("[TB] random stream");
        for (int i = 0; i < 1000; i++) begin
            x = randOperand();
            y = randOperand();
            applyStimulus(x, y, 22'h3FFFFF, refMul(x, y, 22'h3FFFFF));
        end
        idle(1);
        drain();

        $display("[TB] reset during burst");
        for (int i = 0; i < 20; i++) begin
            x = randOperand();
            y = randOperand();
            applyStimulus(x, y, 22'h3FFFFF, refMul(x, y, 22'h3FFFFF));
        end
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        checkOutput("reset_flush_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_flush_result", result, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < PIPE_STAGES + 3; i++) begin
            @(negedge clk);
            checkOutput("no_stale_valid", {31'd0, out_valid}, 32'd0);
        end

        applyStimulus(32'hBFC0_0000, 32'h4000_0000, 22'h3FFFFF, 32'hC040_0000);
        idle(1);
        drain();
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
